// File: rtl/etcpu_main_mem.sv
// etcpu_main_mem: word-organised data RAM answering the core's main-memory port.
// After reset an init sequencer writes INIT_VAL to every word, then the memory
// serves combinational reads and clocked writes and flags illegal accesses.
// Optional feature macro: ETCPU_MAIN_MEM_CNT_EN adds saturating rd_cnt/wr_cnt.
module etcpu_main_mem #(
   parameter int          DEPTH    = 1024,
   parameter logic [31:0] INIT_VAL = 32'h0,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_cs,
   input  logic             mem_wen,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_dat_in,
   output logic [31:0]      mem_dat_out,
   output logic             mem_ready,
   output logic             mem_err,
`ifdef ETCPU_MAIN_MEM_CNT_EN
   output logic [31:0]      mem_err_addr,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] wr_cnt
`else
   output logic [31:0]      mem_err_addr
`endif
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic {ST_INIT, ST_READY} state_t;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   init_ptr_q, init_ptr_d;
   logic               err_q, err_d;
   logic [31:0]        err_addr_q, err_addr_d;
   logic [31:0]        ram_q [DEPTH];

   logic [IDX_W-1:0]   idx;
   logic               legal;
   logic               acc;
   logic               rd_ok;
   logic               wr_ok;
   logic               ill;
   logic               ram_we;
   logic [IDX_W-1:0]   ram_waddr;
   logic [31:0]        ram_wdata;

   // Decode the core access; nothing is honoured before init completes or under reset.
   always_comb begin
      idx   = mem_addr[2 +: IDX_W];
      legal = (mem_addr[1:0] == 2'b00) && ((mem_addr >> (IDX_W + 2)) == 32'd0);
      acc   = (state_q == ST_READY) && mem_cs && !rst;
      rd_ok = acc && !mem_wen && legal;
      wr_ok = acc && mem_wen && legal;
      ill   = acc && !legal;
   end

   // Next-state logic: INIT walks every word once, READY is left only by reset.
   always_comb begin
      state_d    = state_q;
      init_ptr_d = init_ptr_q;
      if (state_q == ST_INIT) begin
         init_ptr_d = init_ptr_q + 1'b1;
         if (init_ptr_q == IDX_W'(DEPTH - 1)) begin
            state_d = ST_READY;
         end
      end
   end

   // Sticky error flag; the address latches only for the first illegal access.
   always_comb begin
      err_d      = err_q | ill;
      err_addr_d = err_addr_q;
      if (ill && !err_q) begin
         err_addr_d = mem_addr;
      end
   end

   // Single RAM write port shared by the init sequencer and legal core writes.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = idx;
      ram_wdata = mem_dat_in;
      if (!rst) begin
         if (state_q == ST_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = init_ptr_q;
            ram_wdata = INIT_VAL;
         end else if (wr_ok) begin
            ram_we = 1'b1;
         end
      end
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         init_ptr_q <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         init_ptr_q <= init_ptr_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   // RAM array; contents are cleared by the init sequence, not by reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[ram_waddr] <= ram_wdata;
      end
   end

   // Zero-latency read path, forced to zero whenever no legal read is in progress.
   always_comb begin
      mem_dat_out = rd_ok ? ram_q[idx] : 32'd0;
   end

   assign mem_ready    = (state_q == ST_READY);
   assign mem_err      = err_q;
   assign mem_err_addr = err_addr_q;

`ifdef ETCPU_MAIN_MEM_CNT_EN
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

   // Access counters advance once per accepted legal read or write.
   always_comb begin
      rd_cnt_d = rd_ok ? sat_inc(rd_cnt_q) : rd_cnt_q;
      wr_cnt_d = wr_ok ? sat_inc(wr_cnt_q) : wr_cnt_q;
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign rd_cnt = rd_cnt_q;
   assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_etcpu_main_mem.sv
// Self-checking bench for etcpu_main_mem: a behavioural memory model is compared
// against the DUT on every falling edge, with directed literal checks on top.
module tb_etcpu_main_mem;

   localparam int          DEPTH    = 1024;
   localparam int          IDX_W    = $clog2(DEPTH);
   localparam logic [31:0] INIT_VAL = 32'h0;
   localparam int          CNT_W    = 4;
   localparam int          CMAX     = (1 << CNT_W) - 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_cs = 1'b0;
   logic        mem_wen = 1'b0;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_dat_in = 32'd0;
   logic [31:0] mem_dat_out;
   logic        mem_ready;
   logic        mem_err;
   logic [31:0] mem_err_addr;
`ifdef ETCPU_MAIN_MEM_CNT_EN
   logic [CNT_W-1:0] rd_cnt;
   logic [CNT_W-1:0] wr_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   etcpu_main_mem #(.DEPTH(DEPTH), .INIT_VAL(INIT_VAL), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_cs       (mem_cs),
      .mem_wen      (mem_wen),
      .mem_addr     (mem_addr),
      .mem_dat_in   (mem_dat_in),
      .mem_dat_out  (mem_dat_out),
      .mem_ready    (mem_ready),
      .mem_err      (mem_err),
`ifdef ETCPU_MAIN_MEM_CNT_EN
      .mem_err_addr (mem_err_addr),
      .rd_cnt       (rd_cnt),
      .wr_cnt       (wr_cnt)
`else
      .mem_err_addr (mem_err_addr)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_mem [DEPTH];
   int          m_cnt = 0;       // clock edges seen with rst low since last reset
   bit          m_valid = 1'b0;  // model has seen a reset
   bit          m_err = 1'b0;
   logic [31:0] m_err_addr = 32'd0;
   int          m_rd = 0;
   int          m_wr = 0;

   function automatic bit is_legal(input logic [31:0] a);
      longint unsigned la;
      la = longint'(a);
      return (la % 4 == 0) && (la < longint'(DEPTH) * 4);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_cnt      <= 0;
         m_valid    <= 1'b1;
         m_err      <= 1'b0;
         m_err_addr <= 32'd0;
         m_rd       <= 0;
         m_wr       <= 0;
      end else if (m_valid) begin
         if (m_cnt < DEPTH) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == DEPTH - 1)
               for (int i = 0; i < DEPTH; i++) m_mem[i] <= INIT_VAL;
         end else if (mem_cs) begin
            if (is_legal(mem_addr)) begin
               if (mem_wen) begin
                  m_mem[mem_addr / 4] <= mem_dat_in;
                  m_wr <= (m_wr == CMAX) ? m_wr : m_wr + 1;
               end else begin
                  m_rd <= (m_rd == CMAX) ? m_rd : m_rd + 1;
               end
            end else begin
               m_err <= 1'b1;
               if (!m_err) m_err_addr <= mem_addr;
            end
         end
      end
   end

   // Compare process: every falling edge once the model has been reset.
   always @(negedge clk) begin
      logic [31:0] exp_dat;
      if (m_valid) begin
         exp_dat = 32'd0;
         if (!rst && m_cnt == DEPTH && mem_cs && !mem_wen && is_legal(mem_addr))
            exp_dat = m_mem[mem_addr / 4];
         chk("cmp_ready",    {31'd0, mem_ready}, {31'd0, (m_cnt == DEPTH)});
         chk("cmp_err",      {31'd0, mem_err},   {31'd0, m_err});
         chk("cmp_err_addr", mem_err_addr,        m_err_addr);
         chk("cmp_dat_out",  mem_dat_out,         exp_dat);
`ifdef ETCPU_MAIN_MEM_CNT_EN
         chk("cmp_rd_cnt",   32'(rd_cnt),         32'(m_rd));
         chk("cmp_wr_cnt",   32'(wr_cnt),         32'(m_wr));
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cs, input logic wen, input logic [31:0] a, input logic [31:0] d);
      mem_cs     = cs;
      mem_wen    = wen;
      mem_addr   = a;
      mem_dat_in = d;
   endtask

   task automatic idle();
      drive(1'b0, 1'($urandom), $urandom, $urandom);
   endtask

   task automatic rand_addr(output logic [31:0] a);
      int sel;
      sel = $urandom_range(0, 15);
      if (sel < 9)       a = 32'($urandom_range(0, 31)) * 4;
      else if (sel < 13) a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (sel < 14) a = (32'($urandom_range(0, 31)) * 4) | 32'($urandom_range(1, 3));
      else               a = 32'(DEPTH * 4) + ($urandom & 32'h0FFF_FFFC);
   endtask

   initial begin
      logic [31:0] a;

      // Test 1: two reset cycles, then the init sweep with a write attempted on edge 5.
      idle();
      rst = 1'b1;
      cyc();
      cyc();
      chk("rst_ready", {31'd0, mem_ready}, 32'd0);
      chk("rst_err_addr", mem_err_addr, 32'd0);
      rst = 1'b0;
      for (int e = 1; e <= DEPTH; e++) begin
         if (e == 5) drive(1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF);
         else        idle();
         cyc();
         if (e == 5)         chk("init_wr_no_err", {31'd0, mem_err}, 32'd0);
         if (e == DEPTH - 1) chk("ready_low_1023", {31'd0, mem_ready}, 32'd0);
         if (e == DEPTH)     chk("ready_high_1024", {31'd0, mem_ready}, 32'd1);
      end
      drive(1'b1, 1'b0, 32'h0, 32'd0);   #1; chk("rd_0_after_init", mem_dat_out, 32'h0);
      drive(1'b1, 1'b0, 32'hFFC, 32'd0); #1; chk("rd_ffc_after_init", mem_dat_out, 32'h0);
      drive(1'b1, 1'b0, 32'h8, 32'd0);   #1; chk("rd_8_init_write_dropped", mem_dat_out, 32'h0);
      cyc();

      // Test 2: write then read back, neighbouring word, chip-select low.
      drive(1'b1, 1'b1, 32'h10, 32'h1234_5678);
      cyc();
      drive(1'b1, 1'b0, 32'h10, 32'd0); #1; chk("rd_10", mem_dat_out, 32'h1234_5678);
      drive(1'b1, 1'b0, 32'h14, 32'd0); #1; chk("rd_14", mem_dat_out, 32'h0);
      drive(1'b0, 1'b0, 32'h10, 32'd0); #1; chk("cs_low_dat", mem_dat_out, 32'h0);
      cyc();

      // Test 3: out-of-range write, then a misaligned read.
      drive(1'b1, 1'b1, 32'h1000, 32'hAAAA_AAAA);
      cyc();
      chk("oob_err", {31'd0, mem_err}, 32'd1);
      chk("oob_err_addr", mem_err_addr, 32'h1000);
      drive(1'b1, 1'b0, 32'h0, 32'd0); #1; chk("rd_0_no_alias", mem_dat_out, 32'h0);
      cyc();
      drive(1'b1, 1'b0, 32'h2, 32'd0); #1; chk("misaligned_dat", mem_dat_out, 32'h0);
      cyc();
      chk("err_addr_kept", mem_err_addr, 32'h1000);

      // Random phase, checked by the model every cycle.
      for (int i = 0; i < 600; i++) begin
         rand_addr(a);
         drive(($urandom_range(0, 3) != 0), 1'($urandom), a, $urandom);
         cyc();
      end
      chk("rand_err_addr_first", mem_err_addr, 32'h1000);

      // Test 5: write, error, one-cycle reset, then re-clear.
      drive(1'b1, 1'b1, 32'h20, 32'hCAFE_0001);
      cyc();
      drive(1'b1, 1'b0, 32'h3, 32'd0);
      cyc();
      idle();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst2_ready", {31'd0, mem_ready}, 32'd0);
      chk("rst2_err", {31'd0, mem_err}, 32'd0);
      chk("rst2_err_addr", mem_err_addr, 32'd0);
      for (int e = 0; e < DEPTH; e++) begin
         idle();
         cyc();
      end
      chk("rst2_ready_back", {31'd0, mem_ready}, 32'd1);
      drive(1'b1, 1'b0, 32'h20, 32'd0); #1; chk("rd_20_cleared", mem_dat_out, INIT_VAL);
      cyc();

`ifdef ETCPU_MAIN_MEM_CNT_EN
      // Test 6: counters, saturation, illegal accesses not counted.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 32'h40 + 32'(i) * 4, $urandom);
         cyc();
      end
      idle();
      chk("cnt_rd_before", 32'(rd_cnt), 32'd1);   // the read of 0x20 above
      for (int i = 0; i < 1; i++) begin
         drive(1'b1, 1'b0, 32'h44, 32'd0);
         cyc();
      end
      idle();
      chk("cnt_wr3", 32'(wr_cnt), 32'd3);
      chk("cnt_rd2", 32'(rd_cnt), 32'd2);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, 32'h48, 32'd0);
         cyc();
      end
      idle();
      chk("cnt_rd_sat", 32'(rd_cnt), 32'd15);
      drive(1'b1, 1'b1, 32'h2000, 32'h1);
      cyc();
      drive(1'b1, 1'b1, 32'h41, 32'h1);
      cyc();
      idle();
      chk("cnt_wr_illegal", 32'(wr_cnt), 32'd3);
      cyc();
`endif

      idle();
      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
